gpr_wb_arbiter: RTL and testbench
=================================

# gpr_wb_arbiter

Write-port arbiter and load scoreboard in front of the BJX1 GPR bank. The bank has one write port (Ro ID/value), shared by the EX stage result and asynchronously returning memory-load results. This block sequences both sources onto that port through a registered output stage. It tracks in-flight load destinations and stalls the pipeline on read-after-write hazards and port conflicts.

## Interface
- LDQ_DEPTH, 4: maximum outstanding loads (power of two, 2..8).
- REG_NONE, 7'h7F: register ID meaning "no write".
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high.
- exWbId  in  7  EX result destination ID; REG_NONE = no write.
- exWbVal  in  32  EX result value.
- ldIssValid  in  1  a load is issued this cycle.
- ldIssId  in  7  load destination; legal range 7'h00..7'h0E (R0..R14).
- ldIssReady  out  1  load tracker can accept an issue.
- ldRspValid  in  1  memory returns the oldest outstanding load's data.
- ldRspVal  in  32  load data.
- ldRspReady  out  1  response accepted this cycle.
- rdIdRs, rdIdRt, rdIdRn  in  7 each  IDs the decode stage reads this cycle.
- regIdRo  out  7  write-port ID to the GPR bank.
- regValRo  out  32  write-port value to the GPR bank.
- exHold  out  1  pipeline stall request.
- ldPending  out  1  at least one load is outstanding.
- ldErr  out  1  sticky: an illegal load destination was issued.

## Operation
- Load tracker: in-order FIFO of LDQ_DEPTH 7-bit IDs, with read/write pointers and an occupancy count of width clog2(LDQ_DEPTH)+1.
- ldIssReady = count < LDQ_DEPTH.
- Accepted issue (ldIssValid & ldIssReady) with an ID in range: push.
- Accepted issue with an ID > 7'h0E: no push; set ldErr until reset.
- ldRspReady = count != 0 & !skidValid.
- Accepted response pops the head ID and pairs it with ldRspVal.
- A response with count == 0 is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance. This includes the full case: a pop while full frees a slot, but ldIssReady is evaluated on the pre-pop count.
- Skid register (one entry: ID + value) holds an EX write displaced by a load response.
- Write-port selection each cycle, highest priority first:
  1. Skid entry, if valid.
  2. Accepted load response.
  3. exWbId != REG_NONE.
  4. Otherwise REG_NONE.
- If an accepted load response and an EX write (exWbId != REG_NONE, skid empty) coincide: the load goes to the port and the EX write is captured into the skid.
- exHold is asserted combinationally when any of the following holds:
  - skidValid;
  - an accepted load response and an EX write collide this cycle;
  - any rdId (ignoring REG_NONE) equals a valid tracker entry, the valid skid ID, or the registered regIdRo.
- While exHold is asserted, the pipeline re-presents the same exWbId next cycle. The block does not de-duplicate; the EX stage must suppress its write while held.
- No bypass: hazard matching includes the entry being popped this cycle.
- Reset: tracker empty, pointers 0, skidValid = 0, regIdRo = REG_NONE, regValRo = 0, ldErr = 0. Consequently exHold = 0, ldIssReady = 1, ldRspReady = 0, ldPending = 0.
- Reset mid-operation discards all outstanding loads and any skid contents. Late responses arriving after reset are ignored because count == 0.

## Timing
- The selected write is registered: regIdRo/regValRo change one cycle after selection, and the bank commits on the following edge. Source-to-bank latency is 2 edges.
- Skid drain: a captured EX write appears on regIdRo 2 cycles after its original cycle. exHold stays asserted through the capture cycle and the drain cycle.
- Hazard release: exHold deasserts in the first cycle in which the matching ID is in no tracker entry, no skid entry, and not on regIdRo.
- ldPending = (count != 0), registered-state derived.
- Throughput: one load response per cycle when the skid is empty; one EX write per cycle when no response arrives.

## Test plan
- Reset, then exWbId=3, exWbVal=0x11 -> regIdRo=3, regValRo=0x11 next cycle; exHold=0 throughout.
- Issue load to R5; two cycles later ldRspValid with 0xAB and exWbId=2 (0x22) in the same cycle -> port shows R5/0xAB, then R2/0x22; exHold=1 for those two cycles; ldRspReady=0 in the cycle the skid is valid.
- Issue loads to R1, R2, R3, R4 -> ldIssReady=0 at count 4; fifth issue ignored; responses retire R1..R4 in order with the matching data values.
- Issue load to R7; present rdIdRs=7 -> exHold=1 until the cycle after R7 leaves regIdRo; rdIdRs=8 alone -> exHold=0.
- Issue load to ID 7'h0F -> ldErr=1 and count unchanged; ldErr remains 1 until reset.
- With 3 loads pending, assert reset for one cycle -> ldPending=0, regIdRo=REG_NONE; a following ldRspValid produces no write.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: merges EX results and returning load data onto the
// single bank write port, tracks outstanding load destinations and raises exHold.
module gpr_wb_arbiter #(
  parameter int unsigned LDQ_DEPTH = 4,
  parameter logic [6:0]  REG_NONE  = 7'h7F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  exWbId,
  input  logic [31:0] exWbVal,
  input  logic        ldIssValid,
  input  logic [6:0]  ldIssId,
  output logic        ldIssReady,
  input  logic        ldRspValid,
  input  logic [31:0] ldRspVal,
  output logic        ldRspReady,
  input  logic [6:0]  rdIdRs,
  input  logic [6:0]  rdIdRt,
  input  logic [6:0]  rdIdRn,
  output logic [6:0]  regIdRo,
  output logic [31:0] regValRo,
  output logic        exHold,
  output logic        ldPending,
  output logic        ldErr
);

  localparam int unsigned PW = $clog2(LDQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [6:0]  LD_ID_MAX = 7'h0E;

  logic [6:0]    ldqId [LDQ_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;

  logic          skidValid;
  logic [6:0]    skidId;
  logic [31:0]   skidVal;

  logic          issAccept, issLegal, push, pop, exWrite, collide, hazard;
  logic [6:0]    selId;
  logic [31:0]   selVal;
  logic [6:0]    rdIds [3];
  logic [LDQ_DEPTH-1:0] entryValid;

  assign ldIssReady = count < CW'(LDQ_DEPTH);
  assign issAccept  = ldIssValid & ldIssReady;
  assign issLegal   = ldIssId <= LD_ID_MAX;
  assign push       = issAccept & issLegal;
  assign ldRspReady = (count != '0) & ~skidValid;
  assign pop        = ldRspValid & ldRspReady;
  assign exWrite    = exWbId != REG_NONE;
  // pop already implies an empty skid, so this is exactly the capture condition
  assign collide    = pop & exWrite;
  assign ldPending  = count != '0;

  assign rdIds[0] = rdIdRs;
  assign rdIds[1] = rdIdRt;
  assign rdIds[2] = rdIdRn;

  always_comb begin
    entryValid = '0;
    for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
      entryValid[i] = {1'b0, PW'(i) - rdPtr} < count;
    end
  end

  // Entry being popped this cycle still counts: no bypass from the response.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned r = 0; r < 3; r++) begin
      if (rdIds[r] != REG_NONE) begin
        if (skidValid && rdIds[r] == skidId) hazard = 1'b1;
        if (rdIds[r] == regIdRo) hazard = 1'b1;
        for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
          if (entryValid[i] && ldqId[i] == rdIds[r]) hazard = 1'b1;
        end
      end
    end
  end

  assign exHold = skidValid | collide | hazard;

  always_comb begin
    selId  = REG_NONE;
    selVal = '0;
    if (skidValid) begin
      selId  = skidId;
      selVal = skidVal;
    end else if (pop) begin
      selId  = ldqId[rdPtr];
      selVal = ldRspVal;
    end else if (exWrite) begin
      selId  = exWbId;
      selVal = exWbVal;
    end
  end

  always_ff @(posedge clock) begin
    if (push) ldqId[wrPtr] <= ldIssId;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      skidValid <= 1'b0;
      skidId    <= REG_NONE;
      skidVal   <= '0;
      regIdRo   <= REG_NONE;
      regValRo  <= '0;
      ldErr     <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (issAccept && !issLegal) ldErr <= 1'b1;
      if (skidValid) begin
        skidValid <= 1'b0;
      end else if (collide) begin
        skidValid <= 1'b1;
        skidId    <= exWbId;
        skidVal   <= exWbVal;
      end
      regIdRo  <= selId;
      regValRo <= selVal;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Randomized bench for gpr_wb_arbiter: queue-based reference model, per-cycle
// control checks and a scoreboard monitor on the registered write port.
module tb_gpr_wb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam logic [6:0]  NONE  = 7'h7F;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  exWbId;
  logic [31:0] exWbVal;
  logic        ldIssValid;
  logic [6:0]  ldIssId;
  logic        ldIssReady;
  logic        ldRspValid;
  logic [31:0] ldRspVal;
  logic        ldRspReady;
  logic [6:0]  rdIdRs, rdIdRt, rdIdRn;
  logic [6:0]  regIdRo;
  logic [31:0] regValRo;
  logic        exHold, ldPending, ldErr;

  gpr_wb_arbiter #(.LDQ_DEPTH(DEPTH), .REG_NONE(NONE)) dut (
    .clock(clock), .reset(reset),
    .exWbId(exWbId), .exWbVal(exWbVal),
    .ldIssValid(ldIssValid), .ldIssId(ldIssId), .ldIssReady(ldIssReady),
    .ldRspValid(ldRspValid), .ldRspVal(ldRspVal), .ldRspReady(ldRspReady),
    .rdIdRs(rdIdRs), .rdIdRt(rdIdRt), .rdIdRn(rdIdRn),
    .regIdRo(regIdRo), .regValRo(regValRo),
    .exHold(exHold), .ldPending(ldPending), .ldErr(ldErr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int nComp = 0;
  int nFail = 0;

  typedef struct {
    logic [6:0]  id;
    logic [31:0] val;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [6:0]  mq[$];
  bit          mSkidV = 0;
  logic [6:0]  mSkidId = NONE;
  logic [31:0] mSkidVal = '0;
  logic [6:0]  mRegId = NONE;
  bit          mErr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit busy(input logic [6:0] id);
    if (id == NONE) return 0;
    if (mSkidV && id == mSkidId) return 1;
    if (id == mRegId) return 1;
    foreach (mq[k]) if (mq[k] == id) return 1;
    return 0;
  endfunction

  // Monitor: every non-empty write-port cycle must match the oldest expected
  // write, and that write must appear exactly one cycle after its selection.
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        chk("portId", regIdRo, sb[0].id);
        chk("portVal", regValRo, sb[0].val);
        void'(sb.pop_front());
      end else if (regIdRo !== NONE) begin
        chk("spuriousWrite", regIdRo, NONE);
      end
    end
  end

  task automatic step(input bit doReset, input int issPct, input int rspPct, input bit idle);
    bit issRdy, rspRdy, rspAcc, exW, hold;
    exp_t e;
    @(posedge clock);
    #1;
    reset      = doReset;
    ldIssValid = !idle && ($urandom_range(99) < issPct);
    if ($urandom_range(9) == 0)
      ldIssId = ($urandom_range(1) == 0) ? 7'h0F : 7'($urandom_range(16, 127));
    else
      ldIssId = 7'($urandom_range(14));
    ldRspValid = !idle && ($urandom_range(99) < rspPct);
    ldRspVal   = $urandom;
    exWbId     = (idle || mSkidV || $urandom_range(9) < 4) ? NONE : 7'($urandom_range(14));
    exWbVal    = $urandom;
    rdIdRs     = ($urandom_range(9) < 3) ? NONE : 7'($urandom_range(15));
    rdIdRt     = ($urandom_range(9) < 5) ? NONE : 7'($urandom_range(15));
    rdIdRn     = ($urandom_range(9) < 7) ? NONE : 7'($urandom_range(15));
    #3;
    issRdy = mq.size() < DEPTH;
    rspRdy = mq.size() != 0 && !mSkidV;
    rspAcc = ldRspValid && rspRdy;
    exW    = exWbId != NONE;
    hold   = mSkidV || (rspAcc && exW) || busy(rdIdRs) || busy(rdIdRt) || busy(rdIdRn);
    chk("ldIssReady", ldIssReady, issRdy);
    chk("ldRspReady", ldRspReady, rspRdy);
    chk("ldPending", ldPending, mq.size() != 0);
    chk("ldErr", ldErr, mErr);
    chk("exHold", exHold, hold);
    if (doReset) begin
      mq.delete();
      mSkidV = 0;
      mRegId = NONE;
      mErr   = 0;
    end else begin
      e.id  = NONE;
      e.val = '0;
      e.due = cyc + 1;
      if (mSkidV) begin
        e.id = mSkidId; e.val = mSkidVal; mSkidV = 0;
      end else if (rspAcc) begin
        e.id = mq[0]; e.val = ldRspVal;
        if (exW) begin
          mSkidV = 1; mSkidId = exWbId; mSkidVal = exWbVal;
        end
      end else if (exW) begin
        e.id = exWbId; e.val = exWbVal;
      end
      if (rspAcc) void'(mq.pop_front());
      if (ldIssValid && issRdy) begin
        if (ldIssId <= 7'h0E) mq.push_back(ldIssId);
        else mErr = 1;
      end
      mRegId = e.id;
      if (e.id != NONE) sb.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b1; exWbId = NONE; exWbVal = '0; ldIssValid = 0; ldIssId = '0;
    ldRspValid = 0; ldRspVal = '0; rdIdRs = NONE; rdIdRt = NONE; rdIdRn = NONE;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      case ((n / 200) % 3)
        0:       step($urandom_range(149) == 0, 40, 40, 0);
        1:       step($urandom_range(149) == 0, 80, 10, 0);
        default: step($urandom_range(149) == 0, 10, 80, 0);
      endcase
    end
    for (int n = 0; n < 6; n++) step(0, 0, 0, 1);
    chk("sbDrained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nComp, nFail);
    $finish;
  end

endmodule
